fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Fetch stage plus IF/ID pipeline register of the 5-stage RISC pipeline. It holds the PC, drives the instruction-memory address, and assembles one- or two-word instructions (opcode word plus optional 16-bit immediate word) into the IF/ID register. It obeys the hazard controller's pc_write, stall_fetch and flush_fetch signals, and feeds decode and the hazard controller's fetch-side register fields.

Parameters:
PC_WIDTH, 32, width of word-addressed PC and imem address
INSTR_WIDTH, 16, width of one instruction-memory word
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pc_write  input  1  1 = PC may update this cycle
stall_fetch  input  1  1 = hold PC, FSM and IF/ID
flush_fetch  input  1  1 = branch taken; redirect PC, kill in-flight fetch
branch_target  input  PC_WIDTH  redirect address, used only when flush_fetch=1
imem_addr  output  PC_WIDTH  instruction-memory address, combinationally equal to pc
imem_data  input  INSTR_WIDTH  word at imem_addr, valid in the same cycle (combinational memory)
if_id_instr  output  INSTR_WIDTH  registered opcode word; 16'h0000 = NOP
if_id_imm  output  INSTR_WIDTH  registered immediate; 0 for one-word instructions
if_id_pc  output  PC_WIDTH  address of if_id_instr's opcode word
if_id_valid  output  1  1 = IF/ID holds a real instruction
if_id_rdst  output  3  if_id_instr[10:8], to hazard controller R_dest_fetch
if_id_rsrc  output  3  if_id_instr[7:5], to hazard controller R_src_fetch

Behaviour:
- Encoding: instr[15:11] opcode, [10:8] Rdst, [7:5] Rsrc. instr[15]=1 marks a two-word instruction; the immediate is the next word.
- Reset (async, rst_n=0): pc=RESET_VECTOR, state=FETCH_OP, pending=0, if_id_instr=0, if_id_imm=0, if_id_pc=0, if_id_valid=0. Takes effect immediately regardless of clk and aborts any two-word fetch in progress.
- The FSM has two states: FETCH_OP and FETCH_IMM. Internal pending register holds the opcode word and its address.
- Priority per edge: flush_fetch > stall_fetch > normal.
- Flush (either state): pc <= branch_target; state <= FETCH_OP; pending is discarded; IF/ID <= bubble (instr=0, imm=0, valid=0, pc unchanged). pc_write is ignored on flush.
- Stall (flush_fetch=0, stall_fetch=1): pc, state, pending and IF/ID all hold.
- Normal, FETCH_OP, imem_data[15]=0: IF/ID <= {imem_data, imm=0, pc, valid=1}; state stays FETCH_OP.
- Normal, FETCH_OP, imem_data[15]=1: pending <= {imem_data, pc}; IF/ID <= bubble; state <= FETCH_IMM.
- Normal, FETCH_IMM: IF/ID <= {pending opcode, imm=imem_data, pending pc, valid=1}; state <= FETCH_OP.
- PC update in normal mode: pc <= pc+1 only when pc_write=1. Addition is modulo 2^PC_WIDTH, so all-ones wraps to 0.
- pc_write=0 with stall_fetch=0 is legal but not produced by the hazard controller. The state and IF/ID advance as normal while pc holds, so the same word is re-read.
- A two-word instruction reaches IF/ID one cycle after its opcode word, with a single bubble in between. Single-word instructions have 1-cycle latency from imem_data to IF/ID.
- if_id_rdst and if_id_rsrc are pure slices of the registered if_id_instr. They read 0 after reset and after a flush.

Test Plan:
- Reset release, imem words 0x1234,0x2345 at 0,1 -> edge1: if_id_instr=0x1234, if_id_pc=0, valid=1, pc=1; edge2: if_id_instr=0x2345, if_id_pc=1, pc=2.
- Two-word: mem[4]=0x8A20, mem[5]=0x00FF, pc=4 -> edge1: valid=0, pc=5; edge2: if_id_instr=0x8A20, if_id_imm=0x00FF, if_id_pc=4, valid=1, if_id_rdst=2, if_id_rsrc=1, pc=6.
- Stall: assert stall_fetch=1 and pc_write=0 for 2 cycles with IF/ID holding pc 7 -> IF/ID and pc unchanged both cycles; release -> the next word at pc 8 loads.
- Flush in FETCH_IMM: opcode 0x8000 fetched at pc 10, then flush_fetch=1 with branch_target=0x40 -> pc=0x40, valid=0, instr=0, state FETCH_OP; next edge loads mem[0x40].
- Flush with stall_fetch=1 in the same cycle, branch_target=0x20 -> flush wins: pc=0x20, IF/ID bubble.
- Wrap and async reset: pc=32'hFFFFFFFF, normal fetch -> pc=0; drop rst_n mid-cycle -> outputs clear immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage and IF/ID pipeline register.
// It holds the PC and drives the instruction-memory address from it. It
// assembles one-word and two-word instructions into IF/ID. A two-word
// instruction is an opcode word with bit 15 set, followed by a 16-bit
// immediate word.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   pc_write        PC may advance this cycle
//   stall_fetch     hold PC, FSM and IF/ID
//   flush_fetch     taken branch: redirect to branch_target and insert a bubble
//   branch_target   redirect address, used only while flush_fetch=1
//   imem_addr       instruction-memory address (equals pc)
//   imem_data       word at imem_addr, valid in the same cycle
//   if_id_*         registered IF/ID contents, plus the rdst/rsrc field slices
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH_OP  | imem_data is an opcode word
// FETCH_IMM | imem_data is the immediate for the opcode held in pending_*
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   stall_fetch,
  input  logic                   flush_fetch,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [INSTR_WIDTH-1:0] if_id_imm,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic [2:0]             if_id_rdst,
  output logic [2:0]             if_id_rsrc
);

  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] pending_instr;
  logic [PC_WIDTH-1:0]    pending_pc;

  assign imem_addr  = pc;
  assign if_id_rdst = if_id_instr[10:8];
  assign if_id_rsrc = if_id_instr[7:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VECTOR;
      state         <= FETCH_OP;
      pending_instr <= '0;
      pending_pc    <= '0;
      if_id_instr   <= '0;
      if_id_imm     <= '0;
      if_id_pc      <= '0;
      if_id_valid   <= 1'b0;
    end else if (flush_fetch) begin
      // Redirect and kill any half-fetched two-word instruction.
      // if_id_pc is left alone on purpose: a bubble keeps the last PC.
      pc            <= branch_target;
      state         <= FETCH_OP;
      pending_instr <= '0;
      pending_pc    <= '0;
      if_id_instr   <= '0;
      if_id_imm     <= '0;
      if_id_valid   <= 1'b0;
    end else if (!stall_fetch) begin
      // Without pc_write the FSM still advances, so the same word is re-read.
      if (pc_write) pc <= pc + PC_WIDTH'(1);
      case (state)
        FETCH_OP: begin
          if (imem_data[INSTR_WIDTH-1]) begin
            pending_instr <= imem_data;
            pending_pc    <= pc;
            if_id_instr   <= '0;
            if_id_imm     <= '0;
            if_id_valid   <= 1'b0;
            state         <= FETCH_IMM;
          end else begin
            if_id_instr <= imem_data;
            if_id_imm   <= '0;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
          end
        end
        FETCH_IMM: begin
          if_id_instr <= pending_instr;
          if_id_imm   <= imem_data;
          if_id_pc    <= pending_pc;
          if_id_valid <= 1'b1;
          state       <= FETCH_OP;
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed testbench for fetch_unit.
// A small combinational memory is indexed by the low 8 bits of the address.
// Each task drives one scenario and checks this packed view of the outputs:
// {if_id_instr, if_id_imm, if_id_pc, if_id_valid, imem_addr}.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        stall_fetch;
  logic        flush_fetch;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [2:0]  if_id_rdst;
  logic [2:0]  if_id_rsrc;

  logic [15:0] mem [0:255];
  int n_assert = 0;
  int n_fail = 0;

  wire [96:0] obs = {if_id_instr, if_id_imm, if_id_pc, if_id_valid, imem_addr};

  assign imem_data = mem[imem_addr[7:0]];

  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_write(pc_write),
    .stall_fetch(stall_fetch),
    .flush_fetch(flush_fetch),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_id_instr(if_id_instr),
    .if_id_imm(if_id_imm),
    .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid),
    .if_id_rdst(if_id_rdst),
    .if_id_rsrc(if_id_rsrc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [96:0] ev(input logic [15:0] instr, input logic [15:0] imm,
                                     input logic [31:0] ipc, input logic valid,
                                     input logic [31:0] pc);
    return {instr, imm, ipc, valid, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0)) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0));
    end
    n_assert++;
    if ({if_id_rdst, if_id_rsrc} !== 6'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 0", {if_id_rdst, if_id_rsrc});
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    step();
    n_assert++;
    if (obs !== ev(16'h1234, 16'h0, 32'd0, 1'b1, 32'd1)) begin
      n_fail++; $display("FAIL single_edge1: got %h expected %h", obs, ev(16'h1234, 16'h0, 32'd0, 1'b1, 32'd1));
    end
    step();
    n_assert++;
    if (obs !== ev(16'h2345, 16'h0, 32'd1, 1'b1, 32'd2)) begin
      n_fail++; $display("FAIL single_edge2: got %h expected %h", obs, ev(16'h2345, 16'h0, 32'd1, 1'b1, 32'd2));
    end
    step();
    step();
    n_assert++;
    if (obs !== ev(16'h0203, 16'h0, 32'd3, 1'b1, 32'd4)) begin
      n_fail++; $display("FAIL single_edge4: got %h expected %h", obs, ev(16'h0203, 16'h0, 32'd3, 1'b1, 32'd4));
    end
  endtask

  task automatic test_two_word();
    step();
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'd3, 1'b0, 32'd5)) begin
      n_fail++; $display("FAIL two_word_bubble: got %h expected %h", obs, ev(16'h0, 16'h0, 32'd3, 1'b0, 32'd5));
    end
    step();
    n_assert++;
    if (obs !== ev(16'h8A20, 16'h00FF, 32'd4, 1'b1, 32'd6)) begin
      n_fail++; $display("FAIL two_word_load: got %h expected %h", obs, ev(16'h8A20, 16'h00FF, 32'd4, 1'b1, 32'd6));
    end
    n_assert++;
    if ({if_id_rdst, if_id_rsrc} !== {3'd2, 3'd1}) begin
      n_fail++; $display("FAIL two_word_fields: got rdst %0d rsrc %0d expected 2 1", if_id_rdst, if_id_rsrc);
    end
  endtask

  task automatic test_stall();
    step();
    step();
    n_assert++;
    if (obs !== ev(16'h0700, 16'h0, 32'd7, 1'b1, 32'd8)) begin
      n_fail++; $display("FAIL stall_setup: got %h expected %h", obs, ev(16'h0700, 16'h0, 32'd7, 1'b1, 32'd8));
    end
    stall_fetch = 1'b1;
    pc_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_assert++;
      if (obs !== ev(16'h0700, 16'h0, 32'd7, 1'b1, 32'd8)) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, ev(16'h0700, 16'h0, 32'd7, 1'b1, 32'd8));
      end
    end
    stall_fetch = 1'b0;
    pc_write = 1'b1;
    step();
    n_assert++;
    if (obs !== ev(16'h0800, 16'h0, 32'd8, 1'b1, 32'd9)) begin
      n_fail++; $display("FAIL stall_release: got %h expected %h", obs, ev(16'h0800, 16'h0, 32'd8, 1'b1, 32'd9));
    end
  endtask

  task automatic test_flush_imm();
    step();
    step();
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'd9, 1'b0, 32'd11)) begin
      n_fail++; $display("FAIL flush_imm_setup: got %h expected %h", obs, ev(16'h0, 16'h0, 32'd9, 1'b0, 32'd11));
    end
    flush_fetch = 1'b1;
    branch_target = 32'h40;
    step();
    flush_fetch = 1'b0;
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'd9, 1'b0, 32'h40)) begin
      n_fail++; $display("FAIL flush_imm_redirect: got %h expected %h", obs, ev(16'h0, 16'h0, 32'd9, 1'b0, 32'h40));
    end
    step();
    n_assert++;
    if (obs !== ev(16'h0740, 16'h0, 32'h40, 1'b1, 32'h41)) begin
      n_fail++; $display("FAIL flush_imm_target: got %h expected %h", obs, ev(16'h0740, 16'h0, 32'h40, 1'b1, 32'h41));
    end
    n_assert++;
    if ({if_id_rdst, if_id_rsrc} !== {3'd7, 3'd2}) begin
      n_fail++; $display("FAIL flush_imm_fields: got rdst %0d rsrc %0d expected 7 2", if_id_rdst, if_id_rsrc);
    end
  endtask

  task automatic test_flush_stall();
    step();
    flush_fetch = 1'b1;
    stall_fetch = 1'b1;
    branch_target = 32'h20;
    step();
    flush_fetch = 1'b0;
    stall_fetch = 1'b0;
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'h40, 1'b0, 32'h20)) begin
      n_fail++; $display("FAIL flush_over_stall: got %h expected %h", obs, ev(16'h0, 16'h0, 32'h40, 1'b0, 32'h20));
    end
    step();
    n_assert++;
    if (obs !== ev(16'h0320, 16'h0, 32'h20, 1'b1, 32'h21)) begin
      n_fail++; $display("FAIL flush_over_stall_next: got %h expected %h", obs, ev(16'h0320, 16'h0, 32'h20, 1'b1, 32'h21));
    end
  endtask

  task automatic test_wrap_async_reset();
    flush_fetch = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    flush_fetch = 1'b0;
    step();
    n_assert++;
    if (obs !== ev(16'h04AB, 16'h0, 32'hFFFF_FFFF, 1'b1, 32'h0)) begin
      n_fail++; $display("FAIL pc_wrap: got %h expected %h", obs, ev(16'h04AB, 16'h0, 32'hFFFF_FFFF, 1'b1, 32'h0));
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0)) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", obs, ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0));
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    flush_fetch = 1'b1;
    branch_target = 32'h41;
    step();
    flush_fetch = 1'b0;
    step();
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h42)) begin
      n_fail++; $display("FAIL abort_setup: got %h expected %h", obs, ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h42));
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (obs !== ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0)) begin
      n_fail++; $display("FAIL abort_reset: got %h expected %h", obs, ev(16'h0, 16'h0, 32'h0, 1'b0, 32'h0));
    end
    #2 rst_n = 1'b1;
    step();
    n_assert++;
    if (obs !== ev(16'h1234, 16'h0, 32'h0, 1'b1, 32'h1)) begin
      n_fail++; $display("FAIL abort_restart: got %h expected %h", obs, ev(16'h1234, 16'h0, 32'h0, 1'b1, 32'h1));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h2345;
    mem[8'h02] = 16'h0102;
    mem[8'h03] = 16'h0203;
    mem[8'h04] = 16'h8A20;
    mem[8'h05] = 16'h00FF;
    mem[8'h06] = 16'h0600;
    mem[8'h07] = 16'h0700;
    mem[8'h08] = 16'h0800;
    mem[8'h09] = 16'h0900;
    mem[8'h0A] = 16'h8000;
    mem[8'h0B] = 16'h0B0B;
    mem[8'h20] = 16'h0320;
    mem[8'h40] = 16'h0740;
    mem[8'h41] = 16'h9111;
    mem[8'hFF] = 16'h04AB;
    rst_n = 1'b0;
    pc_write = 1'b1;
    stall_fetch = 1'b0;
    flush_fetch = 1'b0;
    branch_target = 32'h0;

    test_reset();
    test_single_word();
    test_two_word();
    test_stall();
    test_flush_imm();
    test_flush_stall();
    test_wrap_async_reset();
    test_reset_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
